// File: rtl/mem_arbiter.sv
// Two-port arbiter in front of a single-port RAM: each access is IDLE -> ACCESS -> DONE.
// Define MEM_ARB_ROUND_ROBIN_EN to resolve ties round-robin; otherwise port 1 wins ties.
module mem_arbiter #(
    parameter int AW = 9,
    parameter int DW = 32
) (
    input  logic          clock,
    input  logic          reset_n,
    input  logic          req0,
    input  logic          req1,
    input  logic          we0,
    input  logic          we1,
    input  logic [AW-1:0] addr0,
    input  logic [AW-1:0] addr1,
    input  logic [DW-1:0] wdata0,
    input  logic [DW-1:0] wdata1,
    output logic          gnt0,
    output logic          gnt1,
    output logic          ack0,
    output logic          ack1,
    output logic [DW-1:0] rdata0,
    output logic [DW-1:0] rdata1,
    output logic          mem_read,
    output logic          mem_write,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata,
    output logic          busy,
    output logic [1:0]    dbg_state
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } state_t;

    // Handshake: req/we/addr/wdata must be held until gnt; they are sampled only at the
    // IDLE edge, gnt pulses in the ACCESS cycle, ack pulses in the DONE cycle.
    state_t state;
    logic   win;
    logic   we_l;
    logic   pick;

`ifdef MEM_ARB_ROUND_ROBIN_EN
    logic last;

    always_comb begin
        pick = req1;
        if (req0 && req1)
            pick = ~last;
    end
`else
    // Port 1 wins a tie; a lone request wins by itself.
    always_comb begin
        pick = req1;
    end
`endif

    assign dbg_state = state;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state     <= IDLE;
            win       <= 1'b0;
            we_l      <= 1'b0;
            gnt0      <= 1'b0;
            gnt1      <= 1'b0;
            ack0      <= 1'b0;
            ack1      <= 1'b0;
            rdata0    <= '0;
            rdata1    <= '0;
            mem_read  <= 1'b0;
            mem_write <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            busy      <= 1'b0;
`ifdef MEM_ARB_ROUND_ROBIN_EN
            last      <= 1'b1;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (req0 || req1) begin
                        win       <= pick;
                        we_l      <= pick ? we1 : we0;
                        mem_addr  <= pick ? addr1 : addr0;
                        mem_wdata <= pick ? wdata1 : wdata0;
                        gnt0      <= ~pick;
                        gnt1      <= pick;
                        mem_read  <= ~(pick ? we1 : we0);
                        mem_write <= pick ? we1 : we0;
                        busy      <= 1'b1;
                        state     <= ACCESS;
`ifdef MEM_ARB_ROUND_ROBIN_EN
                        last      <= pick;
`endif
                    end
                end
                ACCESS: begin
                    gnt0      <= 1'b0;
                    gnt1      <= 1'b0;
                    mem_read  <= 1'b0;
                    mem_write <= 1'b0;
                    ack0      <= ~win;
                    ack1      <= win;
                    // RAM output is valid by the end of the ACCESS cycle.
                    if (!we_l) begin
                        if (win)
                            rdata1 <= mem_rdata;
                        else
                            rdata0 <= mem_rdata;
                    end
                    state <= DONE;
                end
                DONE: begin
                    ack0  <= 1'b0;
                    ack1  <= 1'b0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    gnt0      <= 1'b0;
                    gnt1      <= 1'b0;
                    ack0      <= 1'b0;
                    ack1      <= 1'b0;
                    mem_read  <= 1'b0;
                    mem_write <= 1'b0;
                    busy      <= 1'b0;
                    state     <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: expected grants/acks queued at drive time, popped on DUT output.
module tb_mem_arbiter;
    localparam int AW = 9;
    localparam int DW = 32;
`ifdef MEM_ARB_ROUND_ROBIN_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    logic          clock = 1'b0;
    logic          reset_n = 1'b0;
    logic          req0, req1, we0, we1;
    logic [AW-1:0] addr0, addr1;
    logic [DW-1:0] wdata0, wdata1;
    logic          gnt0, gnt1, ack0, ack1;
    logic [DW-1:0] rdata0, rdata1;
    logic          mem_read, mem_write;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata, mem_rdata;
    logic          busy;
    logic [1:0]    dbg_state;

    mem_arbiter #(.AW(AW), .DW(DW)) dut (
        .clock(clock), .reset_n(reset_n),
        .req0(req0), .req1(req1), .we0(we0), .we1(we1),
        .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
        .gnt0(gnt0), .gnt1(gnt1), .ack0(ack0), .ack1(ack1),
        .rdata0(rdata0), .rdata1(rdata1),
        .mem_read(mem_read), .mem_write(mem_write),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
        .busy(busy), .dbg_state(dbg_state)
    );

    // ---------------- clock / reset / RAM ----------------
    always #5 clock = ~clock;

    logic [DW-1:0] ram       [0:(1<<AW)-1];
    logic [DW-1:0] model_mem [0:(1<<AW)-1];
    assign mem_rdata = ram[mem_addr];
    always @(posedge clock) if (mem_write) ram[mem_addr] <= mem_wdata;

    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    // ---------------- scoreboard ----------------
    int n_cmp = 0;
    int n_err = 0;
    logic [63:0] gnt_q[$];   // {p, we, addr[8:0], wdata[31:0]}
    logic [64:0] ack_q[$];   // {p, rdata0, rdata1}
    logic [DW-1:0] shadow0 = '0;
    logic [DW-1:0] shadow1 = '0;
    logic last_srv = 1'b1;
    bit tie_mode = 1'b0;
    int last_gnt_cyc = -1;

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, act, exp, $time);
        end
    endtask

    task automatic push_exp(input logic p, input logic w, input logic [AW-1:0] a,
                            input logic [DW-1:0] d, input bit with_ack);
        gnt_q.push_back({21'b0, p, w, a, d});
        if (with_ack) begin
            if (w) model_mem[a] = d;
            else if (p) shadow1 = model_mem[a];
            else shadow0 = model_mem[a];
            ack_q.push_back({p, shadow0, shadow1});
        end
        last_srv = p;
    endtask

    always @(negedge clock) begin
        if (reset_n) begin
            check("gnt_excl", {63'b0, gnt0 & gnt1}, 64'd0);
            check("ack_excl", {63'b0, ack0 & ack1}, 64'd0);
            check("strobe_excl", {63'b0, mem_read & mem_write}, 64'd0);
            if (gnt0 || gnt1) begin
                if (gnt_q.size() == 0) begin
                    check("gnt_unexp", {62'b0, gnt0, gnt1}, 64'd0);
                end else begin
                    logic [63:0] e;
                    e = gnt_q.pop_front();
                    check("gnt_port", {63'b0, gnt1}, {63'b0, e[42]});
                    check("mem_read", {63'b0, mem_read}, {63'b0, ~e[41]});
                    check("mem_write", {63'b0, mem_write}, {63'b0, e[41]});
                    check("mem_addr", {55'b0, mem_addr}, {55'b0, e[40:32]});
                    if (e[41]) check("mem_wdata", {32'b0, mem_wdata}, {32'b0, e[31:0]});
                    check("busy_acc", {63'b0, busy}, 64'd1);
                    if (tie_mode && last_gnt_cyc >= 0)
                        check("gnt_spacing", 64'(cyc - last_gnt_cyc), 64'd3);
                    last_gnt_cyc = cyc;
                end
            end
            if (ack0 || ack1) begin
                if (ack_q.size() == 0) begin
                    check("ack_unexp", {62'b0, ack0, ack1}, 64'd0);
                end else begin
                    logic [64:0] e;
                    e = ack_q.pop_front();
                    check("ack_port", {63'b0, ack1}, {63'b0, e[64]});
                    check("rdata0", {32'b0, rdata0}, {32'b0, e[63:32]});
                    check("rdata1", {32'b0, rdata1}, {32'b0, e[31:0]});
                    check("done_strobes", {62'b0, mem_read, mem_write}, 64'd0);
                end
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic drive_port(input logic p, input logic r, input logic w,
                              input logic [AW-1:0] a, input logic [DW-1:0] d);
        if (p) begin req1 = r; we1 = w; addr1 = a; wdata1 = d; end
        else   begin req0 = r; we0 = w; addr0 = a; wdata0 = d; end
    endtask

    task automatic access(input logic p, input logic w, input logic [AW-1:0] a,
                          input logic [DW-1:0] d);
        @(negedge clock);
        drive_port(p, 1'b1, w, a, d);
        push_exp(p, w, a, d, 1'b1);
        @(negedge clock);
        check("gnt_lat", {63'b0, p ? gnt1 : gnt0}, 64'd1);
        // Scramble the dropped request to show the latched command is used.
        drive_port(p, 1'b0, $urandom_range(0, 1), AW'($urandom_range(0, 511)), $urandom);
        @(negedge clock);
        check("ack_lat", {63'b0, p ? ack1 : ack0}, 64'd1);
        @(negedge clock);
        check("idle_busy", {63'b0, busy}, 64'd0);
    endtask

    // ---------------- main sequence ----------------
    initial begin
        req0 = 0; req1 = 0; we0 = 0; we1 = 0;
        addr0 = '0; addr1 = '0; wdata0 = '0; wdata1 = '0;
        for (int i = 0; i < (1 << AW); i++) begin
            ram[i] = $urandom;
            model_mem[i] = ram[i];
        end
        ram[9'h010] = 32'hDEADBEEF;
        model_mem[9'h010] = 32'hDEADBEEF;

        #12;
        check("rst_outs", {56'b0, gnt0, gnt1, ack0, ack1, mem_read, mem_write, busy, 1'b0}, 64'd0);
        check("rst_rdata", {rdata0, rdata1}, 64'd0);
        check("rst_mem", {23'b0, mem_addr, mem_wdata}, 64'd0);
        check("rst_state", {62'b0, dbg_state}, 64'd0);
        @(negedge clock);
        reset_n = 1'b1;
        repeat (3) @(negedge clock);
        check("idle_no_req", {63'b0, busy}, 64'd0);

        access(1'b0, 1'b0, 9'h010, '0);
        access(1'b1, 1'b1, 9'h1FF, 32'h12345678);
        access(1'b0, 1'b0, 9'h1FF, '0);

        // Tie held for four accesses.
        @(negedge clock);
        req0 = 1; we0 = 0; addr0 = 9'h020; wdata0 = '0;
        req1 = 1; we1 = 1; addr1 = 9'h030; wdata1 = 32'hA5A5_0001;
        for (int i = 0; i < 4; i++) begin
            logic w;
            w = RR ? ~last_srv : 1'b1;
            push_exp(w, w, w ? 9'h030 : 9'h020, w ? 32'hA5A5_0001 : 32'h0, 1'b1);
        end
        tie_mode = 1'b1;
        last_gnt_cyc = -1;
        repeat (10) @(negedge clock);
        req0 = 0; req1 = 0;
        repeat (3) @(negedge clock);
        tie_mode = 1'b0;

        for (int i = 0; i < 10; i++)
            access(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                   AW'($urandom_range(16, 23)), $urandom);

        // Reset in the middle of a write's ACCESS cycle.
        @(negedge clock);
        drive_port(1'b1, 1'b1, 1'b1, 9'h040, 32'hCAFEF00D);
        push_exp(1'b1, 1'b1, 9'h040, 32'hCAFEF00D, 1'b0);
        @(negedge clock);
        check("rst_pre_wr", {63'b0, mem_write}, 64'd1);
        req1 = 0;
        #1 reset_n = 1'b0;
        #1;
        check("rst_abort", {60'b0, mem_write, busy, gnt1, ack1}, 64'd0);
        check("rst_abort_state", {62'b0, dbg_state}, 64'd0);
        @(negedge clock);
        check("rst_no_ack", {62'b0, ack0, ack1}, 64'd0);
        #2 reset_n = 1'b1;
        shadow0 = '0; shadow1 = '0; last_srv = 1'b1;
        repeat (3) @(negedge clock);
        check("post_rst_idle", {62'b0, busy, dbg_state == 2'd0 ? 1'b0 : 1'b1}, 64'd0);
        check("post_rst_rdata", {rdata0, rdata1}, 64'd0);
        check("post_rst_addr", {55'b0, mem_addr}, 64'd0);

        // Aborted write must not have reached the RAM.
        access(1'b0, 1'b0, 9'h040, '0);
        access(1'b1, 1'b0, 9'h1FF, '0);

        repeat (4) @(negedge clock);
        check("queues_empty", 64'(gnt_q.size() + ack_q.size()), 64'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
